// File: rtl/axi_cosim_pkg.sv
// Shared definitions for the AXI cosimulation fabric.
//
// Holds the AXI encodings used by the BFM, the behavioural memory and the
// channel delay buffers, plus helpers that size and lay out the packed channel
// bundles carried by each axi_chan_delay_fifo instance.
//
// Bundle layout (LSB first) for AW/AR:
//   prot[2:0] | cache[3:0] | lock | burst[1:0] | size[2:0] | len | addr | id
//   (lock is 2 bits and len 4 bits for AXI3, 1 bit and 8 bits for AXI4)
// W: last | strb | data | id (id present for AXI3 only)
// B: resp[1:0] | id
// R: last | resp[1:0] | data | id
package axi_cosim_pkg;

  localparam int unsigned AXI_SIZE_W  = 3;
  localparam int unsigned AXI_BURST_W = 2;
  localparam int unsigned AXI_CACHE_W = 4;
  localparam int unsigned AXI_PROT_W  = 3;
  localparam int unsigned AXI_RESP_W  = 2;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } axi_resp_e;

  function automatic int unsigned axi_len_w(input bit axi3);
    return axi3 ? 4 : 8;
  endfunction

  function automatic int unsigned axi_lock_w(input bit axi3);
    return axi3 ? 2 : 1;
  endfunction

  // Address channel (AW/AR) field offsets.
  function automatic int unsigned ax_off_cache();
    return AXI_PROT_W;
  endfunction

  function automatic int unsigned ax_off_lock();
    return AXI_PROT_W + AXI_CACHE_W;
  endfunction

  function automatic int unsigned ax_off_burst(input bit axi3);
    return ax_off_lock() + axi_lock_w(axi3);
  endfunction

  function automatic int unsigned ax_off_size(input bit axi3);
    return ax_off_burst(axi3) + AXI_BURST_W;
  endfunction

  function automatic int unsigned ax_off_len(input bit axi3);
    return ax_off_size(axi3) + AXI_SIZE_W;
  endfunction

  function automatic int unsigned ax_off_addr(input bit axi3);
    return ax_off_len(axi3) + axi_len_w(axi3);
  endfunction

  function automatic int unsigned ax_off_id(input bit axi3, input int unsigned ad_w);
    return ax_off_addr(axi3) + ad_w;
  endfunction

  // Channel bundle widths.
  function automatic int unsigned ax_width(input int unsigned id_w, input int unsigned ad_w,
                                           input bit axi3);
    return ax_off_id(axi3, ad_w) + id_w;
  endfunction

  function automatic int unsigned w_width(input int unsigned id_w, input int unsigned da_w,
                                          input bit axi3);
    return 1 + da_w / 8 + da_w + (axi3 ? id_w : 0);
  endfunction

  function automatic int unsigned b_width(input int unsigned id_w);
    return AXI_RESP_W + id_w;
  endfunction

  function automatic int unsigned r_width(input int unsigned id_w, input int unsigned da_w);
    return 1 + AXI_RESP_W + da_w + id_w;
  endfunction

  // Width of an occupancy counter that must represent 0..depth.
  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axi_chan_delay_fifo.sv
// Single AXI channel buffer with programmable per-beat latency.
//
// Every accepted beat carries its own countdown, loaded from DELAY when it is
// written. The head beat is offered downstream only once its countdown has
// reached zero; younger beats keep counting down behind it, so strict FIFO
// order is kept while latency overlaps.
//
// Ports:
//   ACLK       clock, rising edge
//   ARESET     asynchronous active-high reset; drops all stored beats
//   DELAY      added latency (cycles) for beats accepted from now on
//   S_PAYLOAD  upstream payload
//   S_VALID    upstream valid
//   S_READY    upstream ready (registered)
//   M_PAYLOAD  downstream payload, head entry
//   M_VALID    downstream valid (from registers only)
//   M_READY    downstream ready
//   LEVEL      number of occupied entries (registered)
module axi_chan_delay_fifo
  import axi_cosim_pkg::*;
#(
  parameter int unsigned WIDTH_PL  = 45,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned WIDTH_DLY = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [WIDTH_DLY-1:0]       DELAY,
  input  logic [WIDTH_PL-1:0]        S_PAYLOAD,
  input  logic                       S_VALID,
  output logic                       S_READY,
  output logic [WIDTH_PL-1:0]        M_PAYLOAD,
  output logic                       M_VALID,
  input  logic                       M_READY,
  output logic [lvl_w(DEPTH)-1:0]    LEVEL
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = lvl_w(DEPTH);

  logic [WIDTH_PL-1:0]  mem_p0 [DEPTH];
  logic [WIDTH_DLY-1:0] cd_p0  [DEPTH];
  logic [PTR_W-1:0]     wptr_p0;
  logic [PTR_W-1:0]     rptr_p0;
  logic [CNT_W-1:0]     count_p0;
  logic [CNT_W-1:0]     count_nxt;
  logic                 s_ready_p0;
  logic                 push;
  logic                 pop;

  // Head is presentable once occupied and its countdown has expired. Both
  // terms are registers, so M_VALID/M_PAYLOAD have no input-to-output path.
  assign M_VALID   = (count_p0 != '0) && (cd_p0[rptr_p0] == '0);
  assign M_PAYLOAD = mem_p0[rptr_p0];
  assign S_READY   = s_ready_p0;
  assign LEVEL     = count_p0;

  assign push = S_VALID && s_ready_p0;
  assign pop  = M_VALID && M_READY;

  always_comb begin
    count_nxt = count_p0;
    case ({push, pop})
      2'b10:   count_nxt = count_p0 + 1'b1;
      2'b01:   count_nxt = count_p0 - 1'b1;
      default: count_nxt = count_p0;
    endcase
  end

  // ---- storage stage: entries, countdowns, pointers, occupancy ----
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_p0[i] <= '0;
        cd_p0[i]  <= '0;
      end
      wptr_p0    <= '0;
      rptr_p0    <= '0;
      count_p0   <= '0;
      s_ready_p0 <= 1'b0;
    end else begin
      // Free entries sit at zero already, so counting every non-zero entry
      // down is the same as counting down only the occupied ones. A beat
      // written this cycle takes DELAY untouched.
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (push && (wptr_p0 == PTR_W'(i))) begin
          mem_p0[i] <= S_PAYLOAD;
          cd_p0[i]  <= DELAY;
        end else if (cd_p0[i] != '0) begin
          cd_p0[i] <= cd_p0[i] - 1'b1;
        end
      end
      if (push) wptr_p0 <= wptr_p0 + 1'b1;
      if (pop)  rptr_p0 <= rptr_p0 + 1'b1;
      count_p0 <= count_nxt;
      // First edge after reset sees count 0, so this also raises ready then.
      s_ready_p0 <= (count_nxt != CNT_W'(DEPTH));
    end
  end

endmodule

// File: tb/tb_axi_chan_delay_fifo.sv
// Directed bench for axi_chan_delay_fifo with a payload scoreboard.
module tb_axi_chan_delay_fifo;

  localparam int unsigned WIDTH_PL  = 45;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned WIDTH_DLY = 4;

  logic                 ACLK = 1'b0;
  logic                 ARESET;
  logic [WIDTH_DLY-1:0] DELAY;
  logic [WIDTH_PL-1:0]  S_PAYLOAD;
  logic                 S_VALID;
  logic                 S_READY;
  logic [WIDTH_PL-1:0]  M_PAYLOAD;
  logic                 M_VALID;
  logic                 M_READY;
  logic [2:0]           LEVEL;

  int checks   = 0;
  int failures = 0;
  logic [WIDTH_PL-1:0] exp_q[$];

  axi_chan_delay_fifo #(
    .WIDTH_PL (WIDTH_PL),
    .DEPTH    (DEPTH),
    .WIDTH_DLY(WIDTH_DLY)
  ) dut (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .DELAY    (DELAY),
    .S_PAYLOAD(S_PAYLOAD),
    .S_VALID  (S_VALID),
    .S_READY  (S_READY),
    .M_PAYLOAD(M_PAYLOAD),
    .M_VALID  (M_VALID),
    .M_READY  (M_READY),
    .LEVEL    (LEVEL)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a handshake visible at the falling edge completes on the next
  // rising edge, so the presented payload must match the oldest expectation.
  always @(negedge ACLK) begin
    if (!ARESET && M_VALID && M_READY) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got 0x%0h expected no beat at %0t", M_PAYLOAD, $time);
      end else begin
        chk("sb_payload", 64'(M_PAYLOAD), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Offer one beat and hold it until accepted; returns after the accepting edge.
  task automatic push(input logic [WIDTH_PL-1:0] d, input logic [WIDTH_DLY-1:0] dly);
    int n;
    n = 0;
    DELAY     = dly;
    S_PAYLOAD = d;
    S_VALID   = 1'b1;
    while (!S_READY && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("push_timeout", 64'(n), 64'd0);
    exp_q.push_back(d);
    tick();
    S_VALID = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    M_READY = 1'b1;
    while (LEVEL != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_level", 64'(LEVEL), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET    = 1'b1;
    DELAY     = '0;
    S_PAYLOAD = '0;
    S_VALID   = 1'b0;
    M_READY   = 1'b0;
    repeat (2) tick();
    chk("rst_s_ready", 64'(S_READY), 64'd0);
    chk("rst_m_valid", 64'(M_VALID), 64'd0);
    chk("rst_level", 64'(LEVEL), 64'd0);
    chk("rst_m_payload", 64'(M_PAYLOAD), 64'd0);
    ARESET = 1'b0;

    // Reset release, DELAY=0: push at edge 3, visible after edge 3, popped at 4.
    tick();                                   // edge 1
    chk("t1_s_ready_e1", 64'(S_READY), 64'd1);
    tick();                                   // edge 2
    S_PAYLOAD = 45'h1;
    S_VALID   = 1'b1;
    M_READY   = 1'b1;
    exp_q.push_back(45'h1);
    tick();                                   // edge 3
    S_VALID = 1'b0;
    chk("t1_m_valid_e3", 64'(M_VALID), 64'd1);
    chk("t1_payload_e3", 64'(M_PAYLOAD), 64'h1);
    chk("t1_level_e3", 64'(LEVEL), 64'd1);
    tick();                                   // edge 4
    chk("t1_level_e4", 64'(LEVEL), 64'd0);
    chk("t1_m_valid_e4", 64'(M_VALID), 64'd0);

    // DELAY=5: valid after edge k+5, not earlier; popped at k+6.
    push(45'hA, 4'd5);                        // edge k
    chk("t2_m_valid_k0", 64'(M_VALID), 64'd0);
    for (int j = 1; j <= 4; j++) begin
      tick();
      chk("t2_m_valid_early", 64'(M_VALID), 64'd0);
    end
    tick();                                   // edge k+5
    chk("t2_m_valid_k5", 64'(M_VALID), 64'd1);
    chk("t2_payload_k5", 64'(M_PAYLOAD), 64'hA);
    tick();                                   // edge k+6
    chk("t2_level_k6", 64'(LEVEL), 64'd0);

    // Fill with M_READY=0, fifth beat held, one pop then it enters.
    M_READY = 1'b0;
    DELAY   = 4'd0;
    S_VALID = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      S_PAYLOAD = 45'(i);
      exp_q.push_back(45'(i));
      tick();
    end
    chk("t3_level_full", 64'(LEVEL), 64'd4);
    chk("t3_s_ready_full", 64'(S_READY), 64'd0);
    S_PAYLOAD = 45'h5;
    tick();
    chk("t3_level_held", 64'(LEVEL), 64'd4);
    chk("t3_head_held", 64'(M_PAYLOAD), 64'h1);
    exp_q.push_back(45'h5);
    M_READY = 1'b1;
    tick();                                   // 0x1 popped, no push
    M_READY = 1'b0;
    chk("t3_level_after_pop", 64'(LEVEL), 64'd3);
    chk("t3_s_ready_reopen", 64'(S_READY), 64'd1);
    tick();                                   // 0x5 accepted
    S_VALID = 1'b0;
    chk("t3_level_refill", 64'(LEVEL), 64'd4);
    chk("t3_head_next", 64'(M_PAYLOAD), 64'h2);
    drain();

    // Ordering: 0xB (DELAY=7) then 0xC (DELAY=0).
    M_READY = 1'b1;
    push(45'hB, 4'd7);                        // edge k
    DELAY     = 4'd0;
    S_PAYLOAD = 45'hC;
    S_VALID   = 1'b1;
    exp_q.push_back(45'hC);
    tick();                                   // edge k+1
    S_VALID = 1'b0;
    repeat (5) tick();                        // edge k+6
    chk("t4_m_valid_k6", 64'(M_VALID), 64'd0);
    tick();                                   // edge k+7
    chk("t4_m_valid_k7", 64'(M_VALID), 64'd1);
    chk("t4_payload_k7", 64'(M_PAYLOAD), 64'hB);
    tick();                                   // edge k+8
    chk("t4_m_valid_k8", 64'(M_VALID), 64'd1);
    chk("t4_payload_k8", 64'(M_PAYLOAD), 64'hC);
    tick();                                   // edge k+9
    chk("t4_m_valid_k9", 64'(M_VALID), 64'd0);

    // Stability under back-pressure.
    M_READY = 1'b0;
    push(45'h1_2345_6789, 4'd2);
    begin
      int n;
      n = 0;
      while (!M_VALID && n < 20) begin
        tick();
        n++;
      end
      chk("t5_wait_valid", 64'(M_VALID), 64'd1);
    end
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("t5_stable_valid", 64'(M_VALID), 64'd1);
      chk("t5_stable_payload", 64'(M_PAYLOAD), 64'h1_2345_6789);
    end
    M_READY = 1'b1;
    tick();
    M_READY = 1'b0;
    chk("t5_level_after", 64'(LEVEL), 64'd0);

    // Mid-stream asynchronous reset.
    push(45'h11, 4'd0);
    push(45'h12, 4'd0);
    push(45'h13, 4'd0);
    chk("t6_level_pre", 64'(LEVEL), 64'd3);
    #2;
    ARESET = 1'b1;
    exp_q.delete();
    #1;
    chk("t6_m_valid_rst", 64'(M_VALID), 64'd0);
    chk("t6_level_rst", 64'(LEVEL), 64'd0);
    chk("t6_s_ready_rst", 64'(S_READY), 64'd0);
    chk("t6_payload_rst", 64'(M_PAYLOAD), 64'd0);
    tick();
    ARESET  = 1'b0;
    M_READY = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("t6_no_stale", 64'(M_VALID), 64'd0);
    end
    push(45'h2A, 4'd1);
    drain();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
